// File: rtl/xor_arb_pkg.sv
// Shared definitions for the xor_oper round-robin sequencer.
package xor_arb_pkg;

  localparam int unsigned XOR_DW  = 4;
  localparam int unsigned XOR_LAT = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

endpackage : xor_arb_pkg

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int unsigned k;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!found && req[IDW'(k)]) begin
        grant[IDW'(k)] = 1'b1;
        idx            = IDW'(k);
        found          = 1'b1;
      end
    end
  end

endmodule : rr_arb

// File: rtl/xor_oper_arb.sv
// Round-robin sequencer sharing one registered xor_oper unit between NREQ requesters;
// one operation in flight, result returned with owner id over a valid/ready channel.
module xor_oper_arb
  import xor_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = XOR_DW,
  parameter  int unsigned LAT  = XOR_LAT,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic [DW-1:0]      xo_a,
  output logic [DW-1:0]      xo_b,
  input  logic [DW-1:0]      xo_co,
  output logic               busy
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;

  rr_arb #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  // Grant is only offered while idle; reset forces it low even though it is combinational.
  assign req_ready = (state == S_IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      xo_a      <= '0;
      xo_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            xo_a  <= req_a[int'(gidx) * int'(DW) +: DW];
            xo_b  <= req_b[int'(gidx) * int'(DW) +: DW];
            id_q  <= gidx;
            busy  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= xo_co;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          // Completed requester drops to lowest priority for the next round.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule : xor_oper_arb

// File: tb/tb_xor_oper_arb.sv
// Scoreboard bench for xor_oper_arb with behavioural xor_oper units (LAT=1 and LAT=3 builds).
module tb_xor_oper_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned IDW  = 2;

  typedef struct {
    int         id;
    logic [3:0] data;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data, xo_a, xo_b, xo_co;

  logic [NREQ-1:0]    req_valid3;
  logic [NREQ*DW-1:0] req_a3, req_b3;
  logic [NREQ-1:0]    req_ready3;
  logic               rsp_valid3, rsp_ready3, busy3;
  logic [IDW-1:0]     rsp_id3;
  logic [DW-1:0]      rsp_data3, xo_a3, xo_b3, xo_co3;

  xor_oper_arb #(.NREQ(NREQ), .DW(DW), .LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .xo_a(xo_a), .xo_b(xo_b),
    .xo_co(xo_co), .busy(busy)
  );

  xor_oper_arb #(.NREQ(NREQ), .DW(DW), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_data(rsp_data3), .xo_a(xo_a3), .xo_b(xo_b3),
    .xo_co(xo_co3), .busy(busy3)
  );

  // Behavioural xor_oper units, reset by rstn = ~rst.
  logic [DW-1:0] p3_0, p3_1;
  always @(posedge clk or posedge rst)
    if (rst) xo_co <= '0; else xo_co <= xo_a ^ xo_b;
  always @(posedge clk or posedge rst)
    if (rst) begin p3_0 <= '0; p3_1 <= '0; xo_co3 <= '0; end
    else begin p3_0 <= xo_a3 ^ xo_b3; p3_1 <= p3_0; xo_co3 <= p3_1; end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_err = 0, n_chk = 0;
  exp_t q[$];
  int   mptr = 0;
  int   last_pop = -10;
  int   last_acc_cyc = -10;
  int   acc_hist[$];
  logic prev_v = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j = (p + k) % NREQ;
      if (v[j]) begin g[j] = 1'b1; return g; end
    end
    return g;
  endfunction

  // Response monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        chk("rsp_id", int'(rsp_id), q[0].id);
        chk("rsp_data", int'(rsp_data), int'(q[0].data));
        if (!prev_v) chk("rsp_latency", cyc - q[0].acc, 3);
        if (rsp_ready) begin
          mptr     = (q[0].id + 1) % NREQ;
          last_pop = cyc;
          void'(q.pop_front());
        end
      end
    end
    prev_v = rst ? 1'b0 : rsp_valid;
  end

  // One cycle of requester-side activity: check the grant, record acceptance.
  task automatic tick(output int acc);
    logic [NREQ-1:0] exp_g;
    logic            idle_m;
    @(negedge clk); #1;
    acc    = -1;
    idle_m = !rst && q.size() == 0 && last_pop != cyc;
    exp_g  = idle_m ? model_grant(req_valid, mptr) : '0;
    chk("req_ready", int'(req_ready), int'(exp_g));
    if (idle_m && (req_valid & req_ready) != '0) begin
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) acc = i;
      q.push_back('{id: acc, data: req_a[acc*DW +: DW] ^ req_b[acc*DW +: DW], acc: cyc});
      last_acc_cyc = cyc;
      acc_hist.push_back(acc);
    end
    @(posedge clk); #1;
    if (acc >= 0) req_valid[acc] = 1'b0;
  endtask

  task automatic raise(input int i, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic wait_acc(input int id, output int got);
    int a;
    got = -1;
    for (int n = 0; n < 40 && got != id; n++) begin tick(a); if (a >= 0) got = a; end
    chk("accept_seen", got, id);
  endtask

  task automatic drain();
    int a;
    int n = 0;
    while (q.size() != 0 && n < 100) begin tick(a); n++; end
    chk("drain_done", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    q.delete();
    mptr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int a, g;
    int accs[$];
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_xo_a", int'(xo_a), 0);
    chk("rst_xo_b", int'(xo_b), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Single request
    raise(0, 4'hF, 4'h9);
    wait_acc(0, g);
    chk("t1_busy_on", int'(busy), 1);
    chk("t1_xo_a", int'(xo_a), 'hF);
    chk("t1_xo_b", int'(xo_b), 'h9);
    drain();
    chk("t1_busy_off", int'(busy), 0);

    // All four at once, from a fresh pointer
    do_reset();
    acc_hist.delete();
    raise(0, 4'hF, 4'h9); raise(1, 4'h6, 4'h9); raise(2, 4'h8, 4'h9); raise(3, 4'h0, 4'h0);
    for (int n = 0; n < 40 && accs.size() < 4; n++) begin
      tick(a);
      if (a >= 0) accs.push_back(last_acc_cyc);
    end
    drain();
    chk("t2_count", acc_hist.size(), 4);
    for (int k = 0; k < 4 && k < acc_hist.size(); k++) chk("t2_order", acc_hist[k], k);
    for (int k = 1; k < accs.size(); k++) chk("t2_spacing", accs[k] - accs[k-1], 4);

    // Fairness: requesters 0 and 2 held continuously
    acc_hist.delete();
    raise(0, 4'h3, 4'h5); raise(2, 4'hA, 4'h1);
    for (int n = 0; n < 60 && acc_hist.size() < 6; n++) begin
      tick(a);
      if (a >= 0) raise(a, 4'($urandom), 4'($urandom));
    end
    req_valid = '0;
    drain();
    chk("t3_count", acc_hist.size(), 6);
    for (int k = 1; k < acc_hist.size(); k++) chk("t3_alternate", int'(acc_hist[k] != acc_hist[k-1]), 1);

    // Backpressure while holding a response
    rsp_ready = 1'b0;
    raise(1, 4'h4, 4'hE);
    wait_acc(1, g);
    for (int n = 0; n < 10 && !rsp_valid; n++) tick(a);
    chk("t4_rsp_valid", int'(rsp_valid), 1);
    raise(3, 4'h2, 4'h7);
    repeat (5) tick(a);
    rsp_ready = 1'b1;
    wait_acc(3, g);
    chk("t4_resume", last_acc_cyc - last_pop, 1);
    drain();

    // Reset during WAIT
    raise(2, 4'h7, 4'h1);
    wait_acc(2, g);
    tick(a);
    rst = 1'b1;
    #1;
    chk("t5_req_ready", int'(req_ready), 0);
    chk("t5_rsp_valid", int'(rsp_valid), 0);
    chk("t5_rsp_id", int'(rsp_id), 0);
    chk("t5_rsp_data", int'(rsp_data), 0);
    chk("t5_xo_a", int'(xo_a), 0);
    chk("t5_xo_b", int'(xo_b), 0);
    chk("t5_busy", int'(busy), 0);
    q.delete(); mptr = 0; req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) tick(a);
    raise(3, 4'hA, 4'h5);
    wait_acc(3, g);
    drain();

    // Randomized traffic with random backpressure and request withdrawal
    for (int n = 0; n < 400; n++) begin
      tick(a);
      rsp_ready = ($urandom_range(2) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) raise(i, 4'($urandom), 4'($urandom));
        else if (req_valid[i] && $urandom_range(19) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // LAT=3 build
    begin
      int t3 = -1;
      req_valid3[1] = 1'b1; req_a3[DW +: DW] = 4'hC; req_b3[DW +: DW] = 4'h3;
      for (int n = 0; n < 10 && t3 < 0; n++) begin
        @(negedge clk);
        if (req_ready3[1]) t3 = cyc;
        @(posedge clk); #1;
        if (t3 >= 0) req_valid3[1] = 1'b0;
      end
      chk("l3_accept", int'(t3 >= 0), 1);
      for (int n = 0; n < 15; n++) begin
        @(negedge clk);
        if (rsp_valid3) begin
          chk("l3_latency", cyc - t3, 5);
          chk("l3_data", int'(rsp_data3), 'hF);
          chk("l3_id", int'(rsp_id3), 1);
          break;
        end
        if (n == 14) chk("l3_rsp_timeout", 0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_xor_oper_arb
